// File: rtl/dmem_store_responder_if.sv
// Bundles the core's data-memory store bus with the store-trace drain port.
// master = core/consumer side, slave = responder side.
interface dmem_store_responder_if;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        log_valid;
   logic        log_ready;
   logic [31:0] log_addr;
   logic [31:0] log_data;

   modport master (
      output MemWrite, DataAdr, WriteData, log_ready,
      input  ReadData, log_valid, log_addr, log_data
   );

   modport slave (
      input  MemWrite, DataAdr, WriteData, log_ready,
      output ReadData, log_valid, log_addr, log_data
   );
endinterface

// File: rtl/dmem_store_responder.sv
// Data-memory responder: word RAM with combinational read, tohost done/pass
// verdict, store counter and a store-trace FIFO drained over valid/ready.
module dmem_store_responder #(
   parameter int          DEPTH_WORDS  = 64,
   parameter logic [31:0] TOHOST_ADDR  = 32'd100,
   parameter logic [31:0] EXPECT_VALUE = 32'd25,
   parameter int          LOG_DEPTH    = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   dmem_store_responder_if.slave  bus,
   output logic                   done,
   output logic                   pass,
   output logic                   misaligned,
   output logic [15:0]            store_count,
   output logic                   log_overflow
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int LW = $clog2(LOG_DEPTH);

   logic [31:0]   ram [DEPTH_WORDS];
   logic [31:0]   fifo_addr [LOG_DEPTH];
   logic [31:0]   fifo_data [LOG_DEPTH];
   logic [LW:0]   wp, rp;
   logic [AW-1:0] widx;
   logic          aligned, store_req, accept, empty, full, pop, push;

   assign widx      = bus.DataAdr[AW+1:2];
   assign aligned   = (bus.DataAdr[1:0] == 2'b00);
   // reset gates acceptance so a clock running during reset cannot touch RAM
   assign store_req = reset & bus.MemWrite & ~done;
   assign accept    = store_req & aligned;

   assign empty = (wp == rp);
   assign full  = (wp[LW] != rp[LW]) && (wp[LW-1:0] == rp[LW-1:0]);
   assign pop   = ~empty & bus.log_ready;
   // a simultaneous pop frees the slot the push needs
   assign push  = accept & (~full | pop);

   assign bus.ReadData  = reset ? ram[widx] : '0;
   assign bus.log_valid = ~empty;
   assign bus.log_addr  = empty ? '0 : fifo_addr[rp[LW-1:0]];
   assign bus.log_data  = empty ? '0 : fifo_data[rp[LW-1:0]];

   always_ff @(posedge clk) begin
      if (accept) ram[widx] <= bus.WriteData;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wp[LW-1:0]] <= bus.DataAdr;
         fifo_data[wp[LW-1:0]] <= bus.WriteData;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp           <= '0;
         rp           <= '0;
         done         <= 1'b0;
         pass         <= 1'b0;
         misaligned   <= 1'b0;
         store_count  <= '0;
         log_overflow <= 1'b0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         if (accept && !push) log_overflow <= 1'b1;
         if (store_req && !aligned) misaligned <= 1'b1;
         if (accept && store_count != 16'hFFFF) store_count <= store_count + 16'd1;
         if (accept && bus.DataAdr == TOHOST_ADDR) begin
            done <= 1'b1;
            pass <= (bus.WriteData == EXPECT_VALUE);
         end
      end
   end
endmodule

// File: tb/tb_dmem_store_responder.sv
// Scoreboard bench for dmem_store_responder: a reference model tracks flags,
// RAM and the expected trace FIFO, which is compared as entries are popped.
module tb_dmem_store_responder;
   logic        clk = 1'b0;
   logic        reset;
   logic        done, pass, misaligned, log_overflow;
   logic [15:0] store_count;

   dmem_store_responder_if bus();

   dmem_store_responder dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .done         (done),
      .pass         (pass),
      .misaligned   (misaligned),
      .store_count  (store_count),
      .log_overflow (log_overflow)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model
   logic [63:0] exp_q[$];
   logic [31:0] m_ram [int];
   logic        m_done, m_pass, m_mis, m_ovf;
   logic [15:0] m_cnt;

   task automatic model_store(input logic [31:0] a, input logic [31:0] d);
      if (m_done) return;
      if (a[1:0] != 2'b00) begin m_mis = 1'b1; return; end
      m_ram[int'(a[7:2])] = d;
      if (m_cnt != 16'hFFFF) m_cnt++;
      if (exp_q.size() < 8) exp_q.push_back({a, d});
      else m_ovf = 1'b1;
      if (a == 32'd100) begin m_done = 1'b1; m_pass = (d == 32'd25); end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      bus.MemWrite = 1'b0; bus.log_ready = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      m_done = 0; m_pass = 0; m_mis = 0; m_ovf = 0; m_cnt = '0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic rdy);
      @(negedge clk);
      bus.MemWrite = 1'b1; bus.DataAdr = a; bus.WriteData = d; bus.log_ready = rdy;
      if (rdy && exp_q.size() != 0) begin
         logic [63:0] e;
         e = exp_q.pop_front();
         n_tests++;
         if ({bus.log_addr, bus.log_data} !== e) begin
            n_fail++;
            $display("FAIL sb_pop_on_store: got %h exp %h", {bus.log_addr, bus.log_data}, e);
         end
      end
      model_store(a, d);
      @(posedge clk); #1;
      bus.MemWrite = 1'b0; bus.log_ready = 1'b0;
   endtask

   // scoreboard pop: compares the DUT head with the oldest expected entry
   task automatic sb_pop(input string nm);
      logic [63:0] e;
      @(negedge clk);
      n_tests++;
      if (exp_q.size() == 0 || bus.log_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s valid: got %b exp_q size %0d", nm, bus.log_valid, exp_q.size());
         return;
      end
      e = exp_q.pop_front();
      n_tests++;
      if ({bus.log_addr, bus.log_data} !== e) begin
         n_fail++;
         $display("FAIL %s entry: got %h exp %h", nm, {bus.log_addr, bus.log_data}, e);
      end
      bus.log_ready = 1'b1;
      @(posedge clk); #1;
      bus.log_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.MemWrite = 0; bus.DataAdr = 32'h10; bus.WriteData = 0; bus.log_ready = 0;
      reset = 1'b0;
      #2;
      n_tests++;
      if ({done, pass, misaligned, log_overflow, bus.log_valid} !== 5'b0 || store_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b cnt %0d exp 0", {done, pass, misaligned, log_overflow, bus.log_valid}, store_count);
      end
      n_tests++;
      if ({bus.log_addr, bus.log_data, bus.ReadData} !== 96'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h exp 0", {bus.log_addr, bus.log_data, bus.ReadData});
      end
      apply_reset();
   endtask

   task automatic test_basic();
      apply_reset();
      store(32'h10, 32'h7, 1'b0);
      @(negedge clk);
      bus.DataAdr = 32'h10; #1;
      n_tests++;
      if (bus.ReadData !== 32'h7 || store_count !== 16'd1 || bus.log_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_store: rd %h cnt %0d v %b exp 7 1 1", bus.ReadData, store_count, bus.log_valid);
      end
      // address alias: upper bits beyond the RAM index are ignored
      bus.DataAdr = 32'h10 + 32'd256; #1;
      n_tests++;
      if (bus.ReadData !== 32'h7) begin
         n_fail++;
         $display("FAIL alias_read: got %h exp 7", bus.ReadData);
      end
      sb_pop("basic_pop");
      @(negedge clk);
      n_tests++;
      if (bus.log_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_empty: got %b exp 0", bus.log_valid);
      end
   endtask

   task automatic test_tohost_pass();
      apply_reset();
      store(32'h20, 32'h55, 1'b0);
      store(32'd100, 32'd25, 1'b0);
      n_tests++;
      if (done !== 1'b1 || pass !== 1'b1) begin
         n_fail++;
         $display("FAIL tohost_pass: done %b pass %b exp 1 1", done, pass);
      end
      store(32'h20, 32'h9, 1'b0);
      @(negedge clk);
      bus.DataAdr = 32'h20; #1;
      n_tests++;
      if (bus.ReadData !== m_ram[8] || store_count !== m_cnt) begin
         n_fail++;
         $display("FAIL frozen: rd %h cnt %0d exp %h %0d", bus.ReadData, store_count, m_ram[8], m_cnt);
      end
      sb_pop("pass_pop0");
      sb_pop("pass_pop1");
   endtask

   task automatic test_tohost_fail();
      apply_reset();
      store(32'd100, 32'hE, 1'b0);
      n_tests++;
      if (done !== 1'b1 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL tohost_fail: done %b pass %b exp 1 0", done, pass);
      end
      store(32'd100, 32'd25, 1'b0);
      @(negedge clk);
      n_tests++;
      if (pass !== m_pass || store_count !== m_cnt) begin
         n_fail++;
         $display("FAIL tohost_sticky: pass %b cnt %0d exp %b %0d", pass, store_count, m_pass, m_cnt);
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 0; i < 9; i++) store(32'(i * 4), 32'h100 + 32'(i), 1'b0);
      @(negedge clk);
      n_tests++;
      if (log_overflow !== 1'b1 || store_count !== 16'd9 || m_cnt !== 16'd9) begin
         n_fail++;
         $display("FAIL overflow: ovf %b cnt %0d exp 1 9", log_overflow, store_count);
      end
      for (int i = 0; i < 8; i++) sb_pop("ovf_drain");
      @(negedge clk);
      n_tests++;
      if (bus.log_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_empty: got %b exp 0", bus.log_valid);
      end
   endtask

   task automatic test_full_push_pop();
      apply_reset();
      for (int i = 0; i < 8; i++) store(32'(i * 4), 32'h200 + 32'(i), 1'b0);
      store(32'hA0, 32'hBEEF, 1'b1);
      @(negedge clk);
      n_tests++;
      if (log_overflow !== 1'b0 || {bus.log_addr, bus.log_data} !== {32'h4, 32'h201}) begin
         n_fail++;
         $display("FAIL full_push_pop: ovf %b head %h exp 0 %h", log_overflow, {bus.log_addr, bus.log_data}, {32'h4, 32'h201});
      end
      for (int i = 0; i < 8; i++) sb_pop("fpp_drain");
   endtask

   task automatic test_misaligned();
      apply_reset();
      store(32'h13, 32'h1234, 1'b0);
      @(negedge clk);
      n_tests++;
      if (misaligned !== 1'b1 || store_count !== 16'd0 || bus.log_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL misaligned: mis %b cnt %0d v %b exp 1 0 0", misaligned, store_count, bus.log_valid);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      store(32'h30, 32'hCAFE, 1'b0);
      store(32'h34, 32'hF00D, 1'b0);
      store(32'h38, 32'hD00D, 1'b0);
      @(negedge clk); #2;
      reset = 1'b0; #1;
      n_tests++;
      if (bus.log_valid !== 1'b0 || store_count !== 16'd0 || bus.ReadData !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid: v %b cnt %0d rd %h exp 0 0 0", bus.log_valid, store_count, bus.ReadData);
      end
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      m_done = 0; m_pass = 0; m_mis = 0; m_ovf = 0; m_cnt = '0;
      bus.DataAdr = 32'h34; #1;
      n_tests++;
      if (bus.ReadData !== m_ram[13]) begin
         n_fail++;
         $display("FAIL ram_retained: got %h exp %h", bus.ReadData, m_ram[13]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tohost_pass();
      test_tohost_fail();
      test_overflow();
      test_full_push_pop();
      test_misaligned();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim time exceeded");
      $fatal(1);
   end
endmodule
